// File: rtl/jam_pkg.sv
// Shared types and helpers for the exhaustive job-assignment solver.
package jam_pkg;

  // Largest supported worker/job count.
  localparam int NMAX = 8;

  // Solver control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } jam_state_e;

  // n! for small n; gives the number of assignments searched.
  function automatic int fact(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Address width for n workers/jobs, never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a permutation of 0..N-1.
// Entry i of the flat vector sits at [i*IW +: IW]. is_last is set when the
// input is fully descending; perm_out is then meaningless.
module jam_next_perm #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N*IW-1:0] perm_in,
  output logic [N*IW-1:0] perm_out,
  output logic            is_last
);

  logic [IW-1:0] p [N];
  logic [IW-1:0] q [N];
  logic [IW-1:0] piv_v;
  logic [IW-1:0] swp_v;
  int            piv;
  int            swp;

  // Pivot search, swap with rightmost larger entry, then reverse the suffix.
  always_comb begin
    for (int i = 0; i < N; i++) p[i] = perm_in[i*IW +: IW];

    // Rightmost position whose entry is smaller than its right neighbour.
    piv = -1;
    for (int i = 0; i < N - 1; i++) begin
      if (p[i] < p[i+1]) piv = i;
    end
    is_last = (piv < 0);

    piv_v = '0;
    for (int i = 0; i < N; i++) begin
      if (i == piv) piv_v = p[i];
    end

    // Rightmost entry right of the pivot that is larger than the pivot.
    swp = 0;
    for (int k = 0; k < N; k++) begin
      if (k > piv && p[k] > piv_v) swp = k;
    end
    swp_v = '0;
    for (int k = 0; k < N; k++) begin
      if (k == swp) swp_v = p[k];
    end

    for (int k = 0; k < N; k++) begin
      q[k] = p[k];
      if (k == piv) q[k] = swp_v;
      else if (k == swp && !is_last) q[k] = piv_v;
    end

    // Suffix right of the pivot is descending; reversing makes it ascending.
    perm_out = '0;
    for (int k = 0; k < N; k++) begin
      perm_out[k*IW +: IW] = q[k];
      if (k > piv) begin
        for (int m = 0; m < N; m++) begin
          if (m == N + piv - k) perm_out[k*IW +: IW] = q[m];
        end
      end
    end
  end

endmodule

// File: rtl/jam_perm_solver.sv
// Exhaustive N x N job-assignment solver. Walks all N! assignments in
// lexicographic order, reading each cost over the W/J address ports, and
// reports the minimum total cost and how many assignments reach it.
// Optional feature macro: JAM_BEST_PERM_EN adds the BestPerm output holding
// the lexicographically first optimal assignment.
//
// Handshake: Start is level-sampled only in IDLE and DONE and launches a
// fresh search on the next edge; Busy is high while searching (ACC/CMP) and
// Start is ignored then; Valid is high in DONE with MinCost/MatchCount
// stable, and drops on the edge that accepts a restart.
module jam_perm_solver
  import jam_pkg::*;
#(
  parameter int  N          = 8,
  parameter int  CW         = 7,
  parameter int  SW         = 10,
  parameter int  MCW        = 4,
  parameter int  AUTO_START = 1,
  localparam int IW         = idx_w(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Start,
  output logic [IW-1:0]  W,
  output logic [IW-1:0]  J,
  input  logic [CW-1:0]  Cost,
  output logic [MCW-1:0] MatchCount,
  output logic [SW-1:0]  MinCost,
  output logic           Valid,
  output logic           Busy,
`ifdef JAM_BEST_PERM_EN
  output logic [N*IW-1:0] BestPerm,
`endif
  output jam_state_e     dbg_state
);

  if (N < 2 || N > NMAX) begin : g_bad_n
    $error("jam_perm_solver: N out of range");
  end
  if (SW < CW + $clog2(N)) begin : g_bad_sw
    $error("jam_perm_solver: SW too narrow for N*max cost");
  end

  jam_state_e      state_q, state_d;
  logic            launch;
  logic            idx_end;
  logic            improve;
  logic [IW-1:0]   idx_q;
  logic [SW-1:0]   sum_q;
  logic [SW-1:0]   minreg_q;
  logic [MCW-1:0]  cnt_q;
  logic [N*IW-1:0] perm_q;
  logic [N*IW-1:0] perm_nxt;
  logic [N*IW-1:0] perm_ident;
  logic            perm_last;
  logic [IW-1:0]   w_q;
  logic [IW-1:0]   j_q;

  assign idx_end = (idx_q == IW'(N - 1));
  assign improve = (state_q == CMP) && (sum_q < minreg_q);

  // Identity permutation: worker i takes job i.
  always_comb begin
    perm_ident = '0;
    for (int i = 0; i < N; i++) perm_ident[i*IW +: IW] = IW'(i);
  end

  jam_next_perm #(.N(N), .IW(IW)) u_next_perm (
    .perm_in  (perm_q),
    .perm_out (perm_nxt),
    .is_last  (perm_last)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; launch marks acceptance of a new search.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start || AUTO_START != 0) begin
          state_d = ACC;
          launch  = 1'b1;
        end
      end
      ACC:  if (idx_end) state_d = CMP;
      CMP:  state_d = perm_last ? DONE : ACC;
      DONE: begin
        if (Start) begin
          state_d = ACC;
          launch  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: cost accumulation, min/count update, permutation stepping, W/J.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q    <= '0;
      sum_q    <= '0;
      minreg_q <= '0;
      cnt_q    <= '0;
      perm_q   <= perm_ident;
      w_q      <= '0;
      j_q      <= '0;
    end else begin
      unique case (state_q)
        ACC: begin
          sum_q <= sum_q + SW'(Cost);
          if (idx_end) begin
            idx_q <= '0;
            w_q   <= '0;
            j_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
            w_q   <= idx_q + 1'b1;
            j_q   <= perm_q[(int'(idx_q) + 1)*IW +: IW];
          end
        end
        CMP: begin
          if (improve) begin
            minreg_q <= sum_q;
            cnt_q    <= MCW'(1);
          end else if (sum_q == minreg_q && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
          sum_q <= '0;
          idx_q <= '0;
          w_q   <= '0;
          if (!perm_last) begin
            perm_q <= perm_nxt;
            j_q    <= perm_nxt[IW-1:0];
          end else begin
            j_q <= '0;
          end
        end
        default: begin
          w_q <= '0;
          j_q <= '0;
          if (launch) begin
            minreg_q <= '1;
            cnt_q    <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            perm_q   <= perm_ident;
            j_q      <= perm_ident[IW-1:0];
          end
        end
      endcase
    end
  end

`ifdef JAM_BEST_PERM_EN
  logic [N*IW-1:0] best_q;

  // Capture only on strict improvement so the first optimum found is kept.
  always_ff @(posedge CLK) begin
    if (RST)          best_q <= '0;
    else if (improve) best_q <= perm_q;
  end

  assign BestPerm = best_q;
`endif

  assign W          = w_q;
  assign J          = j_q;
  assign MinCost    = minreg_q;
  assign MatchCount = cnt_q;
  assign Valid      = (state_q == DONE);
  assign Busy       = (state_q == ACC) || (state_q == CMP);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_jam_perm_solver.sv
// Bench for jam_perm_solver: four instances (N=3 auto-start, N=4 MCW=4,
// N=4 MCW=5, N=6) sharing one clock, each with its own cost table, reset and
// start. Results are checked against constants and a brute-force model that
// enumerates every N-digit base-N tuple and keeps the permutations.
`timescale 1ns/1ps
module tb_jam_perm_solver;
  import jam_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] tab [4][8][8];
  logic       rst_v   [4];
  logic       start_v [4];

  logic [1:0] w0, j0, w1, j1, w2, j2;
  logic [2:0] w3, j3;
  logic [6:0] cost0, cost1, cost2, cost3;
  logic [3:0] mc0, mc1, mc3;
  logic [4:0] mc2;
  logic [9:0] min0, min1, min2, min3;
  logic       val0, val1, val2, val3, busy0, busy1, busy2, busy3;
  jam_state_e st0, st1, st2, st3;
`ifdef JAM_BEST_PERM_EN
  logic [5:0]  bp0, bp1, bp2;
  logic [17:0] bp3;
`endif

  assign cost0 = tab[0][3'(w0)][3'(j0)];
  assign cost1 = tab[1][3'(w1)][3'(j1)];
  assign cost2 = tab[2][3'(w2)][3'(j2)];
  assign cost3 = tab[3][w3][j3];

  jam_perm_solver #(.N(3), .CW(7), .SW(10), .MCW(4), .AUTO_START(1)) dut_a (
    .CLK(clk), .RST(rst_v[0]), .Start(start_v[0]), .W(w0), .J(j0), .Cost(cost0),
    .MatchCount(mc0), .MinCost(min0), .Valid(val0), .Busy(busy0),
`ifdef JAM_BEST_PERM_EN
    .BestPerm(bp0),
`endif
    .dbg_state(st0));

  jam_perm_solver #(.N(4), .CW(7), .SW(10), .MCW(4), .AUTO_START(0)) dut_b (
    .CLK(clk), .RST(rst_v[1]), .Start(start_v[1]), .W(w1), .J(j1), .Cost(cost1),
    .MatchCount(mc1), .MinCost(min1), .Valid(val1), .Busy(busy1),
`ifdef JAM_BEST_PERM_EN
    .BestPerm(bp1),
`endif
    .dbg_state(st1));

  jam_perm_solver #(.N(4), .CW(7), .SW(10), .MCW(5), .AUTO_START(0)) dut_c (
    .CLK(clk), .RST(rst_v[2]), .Start(start_v[2]), .W(w2), .J(j2), .Cost(cost2),
    .MatchCount(mc2), .MinCost(min2), .Valid(val2), .Busy(busy2),
`ifdef JAM_BEST_PERM_EN
    .BestPerm(bp2),
`endif
    .dbg_state(st2));

  jam_perm_solver #(.N(6), .CW(7), .SW(10), .MCW(4), .AUTO_START(0)) dut_d (
    .CLK(clk), .RST(rst_v[3]), .Start(start_v[3]), .W(w3), .J(j3), .Cost(cost3),
    .MatchCount(mc3), .MinCost(min3), .Valid(val3), .Busy(busy3),
`ifdef JAM_BEST_PERM_EN
    .BestPerm(bp3),
`endif
    .dbg_state(st3));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int n_of(input int d);
    case (d)
      0:       return 3;
      1, 2:    return 4;
      default: return 6;
    endcase
  endfunction
  function automatic int mcw_of(input int d); return (d == 2) ? 5 : 4; endfunction
  function automatic int iw_of(input int d);  return (d == 3) ? 3 : 2; endfunction

  function automatic longint get_min(input int d);
    case (d) 0: return min0; 1: return min1; 2: return min2; default: return min3; endcase
  endfunction
  function automatic longint get_mc(input int d);
    case (d) 0: return mc0; 1: return mc1; 2: return mc2; default: return mc3; endcase
  endfunction
  function automatic longint get_w(input int d);
    case (d) 0: return w0; 1: return w1; 2: return w2; default: return w3; endcase
  endfunction
  function automatic longint get_j(input int d);
    case (d) 0: return j0; 1: return j1; 2: return j2; default: return j3; endcase
  endfunction
  function automatic logic get_valid(input int d);
    case (d) 0: return val0; 1: return val1; 2: return val2; default: return val3; endcase
  endfunction
  function automatic logic get_busy(input int d);
    case (d) 0: return busy0; 1: return busy1; 2: return busy2; default: return busy3; endcase
  endfunction
  function automatic jam_state_e get_st(input int d);
    case (d) 0: return st0; 1: return st1; 2: return st2; default: return st3; endcase
  endfunction
`ifdef JAM_BEST_PERM_EN
  function automatic longint get_bp(input int d);
    case (d) 0: return bp0; 1: return bp1; 2: return bp2; default: return bp3; endcase
  endfunction
`endif

  // Cost table kinds: 0 const p, 1 diag 0 else p, 2 (i+1)(j+1), 3 i+j,
  // 4 (i*8+j)%13+1, other: random 0..p.
  task automatic set_table(input int d, input int kind, input int p);
    int n, v;
    n = n_of(d);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        case (kind)
          0:       v = p;
          1:       v = (i == j) ? 0 : p;
          2:       v = (i + 1) * (j + 1);
          3:       v = i + j;
          4:       v = (i * 8 + j) % 13 + 1;
          default: v = int'($urandom_range(0, p));
        endcase
        tab[d][i][j] = (i < n && j < n) ? 7'(v) : 7'd0;
      end
    end
  endtask

  // Reference: brute force over all base-N tuples, worker 0 most significant,
  // so tuples are visited in lexicographic order.
  int     m_min, m_cnt;
  longint m_bp;
  function automatic void model(input int d);
    int n, total, c, s, used;
    int dig [8];
    bit ok;
    n = n_of(d);
    total = 1;
    for (int i = 0; i < n; i++) total = total * n;
    m_min = 32'h7fffffff;
    m_cnt = 0;
    m_bp  = 0;
    for (int code = 0; code < total; code++) begin
      c = code;
      for (int i = n - 1; i >= 0; i--) begin
        dig[i] = c % n;
        c = c / n;
      end
      used = 0; ok = 1'b1; s = 0;
      for (int i = 0; i < n; i++) begin
        if (used[dig[i]]) ok = 1'b0;
        used = used | (1 << dig[i]);
        s = s + int'(tab[d][i][dig[i]]);
      end
      if (ok) begin
        if (s < m_min) begin
          m_min = s;
          m_cnt = 1;
          m_bp  = 0;
          for (int i = 0; i < n; i++) m_bp = m_bp | (longint'(dig[i]) << (i * iw_of(d)));
        end else if (s == m_min) begin
          m_cnt++;
        end
      end
    end
  endfunction

  task automatic check_model(input int d, input string name);
    int sat;
    model(d);
    sat = (1 << mcw_of(d)) - 1;
    check({name, " MinCost/model"}, get_min(d), m_min);
    check({name, " MatchCount/model"}, get_mc(d), (m_cnt > sat) ? sat : m_cnt);
`ifdef JAM_BEST_PERM_EN
    check({name, " BestPerm/model"}, get_bp(d), m_bp);
`endif
  endtask

  function automatic int lat_of(input int d);
    return fact(n_of(d)) * (n_of(d) + 1) + 1;
  endfunction

  // Counts edges from the current negedge until Valid is seen (bounded).
  task automatic wait_valid(input int d, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      start_v[d] = 1'b0;
      cyc++;
    end while (!get_valid(d) && cyc < lat_of(d) + 50);
  endtask

  task automatic run(input int d, input bit via_rst, output int cyc);
    if (via_rst) begin
      rst_v[d] = 1'b1;
      @(negedge clk);
      rst_v[d] = 1'b0;
    end else begin
      start_v[d] = 1'b1;
    end
    wait_valid(d, cyc);
  endtask

  typedef struct {
    int kind;
    int p;
    int exp_min;
    int exp_cnt;
  } vec_t;

  vec_t   vecs [7];
  int     cyc, rng;
  longint ident6;

  initial begin
    // N=4, MCW=4 expectations (24 assignments, count saturates at 15).
    vecs[0] = '{0, 5,   20,  15};
    vecs[1] = '{0, 127, 508, 15};
    vecs[2] = '{0, 0,   0,   15};
    vecs[3] = '{1, 100, 0,   1};
    vecs[4] = '{2, 0,   20,  1};
    vecs[5] = '{3, 0,   12,  15};
    vecs[6] = '{4, 0,   19,  12};

    for (int d = 0; d < 4; d++) begin
      rst_v[d]   = 1'b1;
      start_v[d] = 1'b0;
      set_table(d, 0, 0);
    end
    repeat (3) @(negedge clk);

    // Reset state on every instance.
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst%0d Valid", d), get_valid(d), 0);
      check($sformatf("rst%0d Busy", d), get_busy(d), 0);
      check($sformatf("rst%0d MinCost", d), get_min(d), 0);
      check($sformatf("rst%0d MatchCount", d), get_mc(d), 0);
      check($sformatf("rst%0d W", d), get_w(d), 0);
      check($sformatf("rst%0d J", d), get_j(d), 0);
      check($sformatf("rst%0d state", d), get_st(d), IDLE);
`ifdef JAM_BEST_PERM_EN
      check($sformatf("rst%0d BestPerm", d), get_bp(d), 0);
`endif
    end
    rst_v[1] = 1'b0;
    rst_v[2] = 1'b0;
    rst_v[3] = 1'b0;

    // N=3 product table, auto-start.
    set_table(0, 2, 0);
    run(0, 1'b1, cyc);
    check("t1 latency", cyc, 25);
    check("t1 MinCost", min0, 10);
    check("t1 MatchCount", mc0, 1);
`ifdef JAM_BEST_PERM_EN
    check("t1 BestPerm", bp0, 6);
`endif
    check_model(0, "t1");

    // Without auto-start nothing moves until Start.
    check("idle Busy", busy1, 0);
    check("idle Valid", val1, 0);
    check("idle state", st1, IDLE);
    check("idle W", w1, 0);

    // Table-driven vectors on N=4, MCW=4.
    for (int v = 0; v < 7; v++) begin
      set_table(1, vecs[v].kind, vecs[v].p);
      run(1, 1'b0, cyc);
      check($sformatf("vec%0d latency", v), cyc, 121);
      check($sformatf("vec%0d MinCost", v), min1, vecs[v].exp_min);
      check($sformatf("vec%0d MatchCount", v), mc1, vecs[v].exp_cnt);
      check_model(1, $sformatf("vec%0d", v));
    end

    // Start pulsed while busy must not disturb the run.
    set_table(1, 1, 100);
    start_v[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start_v[1] = (cyc == 30);
    end while (!val1 && cyc < 1000);
    start_v[1] = 1'b0;
    check("busy-start latency", cyc, 121);
    check("busy-start MinCost", min1, 0);
    check("busy-start MatchCount", mc1, 1);

    // Restart from DONE with a new table; Valid drops right away.
    set_table(1, 0, 5);
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    check("restart Valid low", val1, 0);
    check("restart Busy high", busy1, 1);
    wait_valid(1, cyc);
    check("restart latency", cyc + 1, 121);
    check("restart MinCost", min1, 20);
    check("restart MatchCount", mc1, 15);

    // Wider count does not saturate at 24.
    set_table(2, 0, 5);
    run(2, 1'b0, cyc);
    check("mcw5 latency", cyc, 121);
    check("mcw5 MinCost", min2, 20);
    check("mcw5 MatchCount", mc2, 24);

    // Mid-run reset aborts, clears, then auto-start reruns from scratch.
    set_table(0, 4, 0);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst Busy before", busy0, 1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("midrst Valid", val0, 0);
    check("midrst Busy", busy0, 0);
    check("midrst MinCost", min0, 0);
    check("midrst MatchCount", mc0, 0);
    check("midrst W", w0, 0);
    check("midrst J", j0, 0);
    check("midrst state", st0, IDLE);
    wait_valid(0, cyc);
    check("midrst latency", cyc, 25);
    check_model(0, "midrst");

    // Randomized tables on N=3 and N=4 (small ranges force ties).
    for (int r = 0; r < 6; r++) begin
      rng = (r % 3 == 0) ? 2 : ((r % 3 == 1) ? 15 : 127);
      set_table(0, 5, rng);
      run(0, r[0], cyc);
      check($sformatf("rand_a%0d latency", r), cyc, 25);
      check_model(0, $sformatf("rand_a%0d", r));
      set_table(1, 5, rng);
      run(1, 1'b0, cyc);
      check($sformatf("rand_b%0d latency", r), cyc, 121);
      check_model(1, $sformatf("rand_b%0d", r));
    end

    // N=6: diagonal zero gives a unique optimum at identity.
    set_table(3, 1, 100);
    run(3, 1'b0, cyc);
    check("diag6 latency", cyc, 5041);
    check("diag6 MinCost", min3, 0);
    check("diag6 MatchCount", mc3, 1);
    ident6 = 0;
    for (int i = 0; i < 6; i++) ident6 = ident6 | (longint'(i) << (i * 3));
`ifdef JAM_BEST_PERM_EN
    check("diag6 BestPerm", bp3, ident6);
`endif
    check_model(3, "diag6");

    set_table(3, 4, 0);
    run(3, 1'b0, cyc);
    check("mod13 latency", cyc, 5041);
    check_model(3, "mod13");

    for (int r = 0; r < 2; r++) begin
      set_table(3, 5, (r == 0) ? 127 : 3);
      run(3, 1'b0, cyc);
      check($sformatf("rand_d%0d latency", r), cyc, 5041);
      check_model(3, $sformatf("rand_d%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
